fifo_ctl: RTL and testbench
===========================

# fifo_ctl

Parametrised synchronous FIFO and the next generation of the UART controller's TX/RX buffer. It adds a fill-level count, programmable almost-full and almost-empty flags, and well-defined simultaneous read/write. It also adds sticky overflow/underflow error flags and an optional first-word-fall-through read mode. It sits between the UART shifter and the host-side register interface, one instance per direction.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- AW (localparam), $clog2(DEPTH), address width
---
- clk  in  1  single clock; all state updates on rising edge only
- rst  in  1  asynchronous, active-high reset
- wr  in  1  write request
- din  in  WIDTH  write data
- rd  in  1  read request
- clr_err  in  1  synchronous clear of overflow/underflow
- dout  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  AW+1  current number of stored words, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was dropped

## Operation
- Pointers: waddr and raddr, each AW+1 bits wide (wrap bit in the MSB), wrapping modulo 2·DEPTH.
  - Memory index is ptr[AW-1:0].
  - count = waddr − raddr, modulo 2^(AW+1).
- Accept rules, evaluated from state before the edge:
  - wr_ok = wr & (!full | rd_ok)
  - rd_ok = rd & !empty
- Simultaneous events:
  - rd and wr while full: both accepted, count unchanged.
  - rd and wr while empty: only the write is accepted. The read is dropped and sets underflow.
  - rd and wr otherwise: both accepted, count unchanged.
- Errors:
  - overflow sets when wr & !wr_ok.
  - underflow sets when rd & !rd_ok.
  - Both flags stay set until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the flag stays set.
- Storage: storage contents are not reset. Only the pointers, flags and dout are reset.
- All status outputs (full, empty, almost_*, count) decode combinationally from registered pointers. There is no half-cycle or negedge logic.

## Timing
- Reset values:
  - count = 0, empty = 1, full = 0, overflow = 0, underflow = 0, dout = 0.
  - almost_empty = 1 (since AE_LEVEL ≥ 0); almost_full = 0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock.
- Write latency: a word written at edge N is readable (empty deasserts) right after edge N.
- Read, standard mode: dout is loaded at the edge where rd_ok = 1. It is valid from that edge and holds until the next accepted read.
- Flags: full, empty and count reflect an accepted operation right after the same edge.
- Wrap: pointers pass DEPTH−1 → 0 in the index bits with no bubble. Sustained rd+wr at any fill level gives throughput of 1 word per cycle.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - dout continuously shows mem[raddr] whenever !empty (combinational from storage).
  - rd_ok pops the head; the next word appears after that edge.
  - dout is don't-care while empty; the bench must not check it.
- FIFO_FWFT_EN undefined: standard registered read as described under Timing.
- Accept rules, flags and count are identical in both modes.

## Structure
- Package fifo_pkg:
  - ptr_t and cnt_t width helpers.
  - A function computing count from two pointers.
  - Default WIDTH/DEPTH constants shared with the UART controller top.
- Sub-module fifo_mem: simple dual-port array with one write port (we, waddr, wdata) and one read port.
  - The read port is asynchronous; fifo_ctl registers its output in standard mode.
  - All pointer, flag and error logic lives in fifo_ctl.

## Test plan
- Reset, then 16 writes of 0x00..0x0F (DEPTH=16, no reads).
  - After write 14: almost_full = 1.
  - After write 16: full = 1, count = 16.
- 17th write of 0xAA while full with no read: count stays 16, overflow = 1. Then 16 reads return 0x00..0x0F; 0xAA never appears.
- Read while empty: underflow = 1, dout unchanged.
  - Pulse clr_err: underflow = 0.
  - Assert clr_err together with a new bad read: underflow stays 1.
- Fill to 16, then 40 cycles of simultaneous rd+wr with an incrementing pattern: count fixed at 16, no overflow, output sequence continuous across pointer wrap.
- Empty FIFO, rd+wr of 0x5C in the same cycle: underflow = 1, count = 1, 0x5C read back next.
  - With FIFO_FWFT_EN: 0x5C appears on dout right after the write edge.
- Assert rst mid-burst at count = 7 (no clock edge): count = 0, empty = 1, dout = 0, flags cleared immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, default geometry and pointer arithmetic for the
// UART TX/RX buffers.
package fifo_pkg;

  // Default geometry shared with the UART controller top.
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  // Pointer carries one wrap bit above the index; count spans 0..DEPTH.
  typedef logic [DEFAULT_AW:0] ptr_t;
  typedef logic [DEFAULT_AW:0] cnt_t;

  // Fill level from two wrap-bit pointers, modulo 2^ptr_bits.
  function automatic logic [31:0] ptr_count(input logic [31:0] wptr,
                                            input logic [31:0] rptr,
                                            input int          ptr_bits);
    logic [31:0] mask;
    mask = (32'd1 << ptr_bits) - 32'd1;
    return (wptr - rptr) & mask;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage array, one synchronous write port and
// one asynchronous read port.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word at the write index on an accepted write.
  // NOTE: the array has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctl.sv
// fifo_ctl: synchronous FIFO controller with fill count, almost flags and
// sticky overflow/underflow errors.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads;
// otherwise dout is registered on each accepted read.
module fifo_ctl
  import fifo_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam int        CW      = AW + 1;
  localparam logic [AW:0] FULL_LVL = CW'(DEPTH);
  localparam logic [AW:0] AF_LVL   = CW'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL   = CW'(AE_LEVEL);

  logic [AW:0]      waddr_q, waddr_d;
  logic [AW:0]      raddr_q, raddr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Status decodes straight from the registered pointers.
  assign count        = CW'(ptr_count(32'(waddr_q), 32'(raddr_q), CW));
  assign full         = (count == FULL_LVL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read frees a slot in the same cycle, so a full FIFO still takes rd+wr.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  // Next pointers and sticky error flags; a new error wins over clr_err.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    waddr_d     = waddr_q + CW'(wr_ok);
    raddr_d     = raddr_q + CW'(rd_ok);
    overflow_d  = (overflow_q  & ~clr_err) | (wr & ~wr_ok);
    underflow_d = (underflow_q & ~clr_err) | (rd & ~rd_ok);
  end

  // Pointer and error registers; reset discards contents without a clock.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (waddr_q[AW-1:0]),
    .wdata (din),
    .raddr (raddr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head word falls through to dout; meaningless while empty.
  assign dout = mem_rdata;
`else
  logic [WIDTH-1:0] dout_q;

  // Registered read: load the head word on each accepted read, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        dout_q <= '0;
    else if (rd_ok) dout_q <= mem_rdata;
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_fifo_ctl.sv
// tb_fifo_ctl: directed self-checking bench for fifo_ctl with a queue
// scoreboard of expected read data.
module tb_fifo_ctl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr, rd, clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full, empty, almost_full, almost_empty;
  logic [4:0]       count;
  logic             overflow, underflow;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] sb [$];
  logic             m_ov, m_un;
  logic [WIDTH-1:0] m_dout;

  always #5 clk = ~clk;

  fifo_ctl #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .din          (din),
    .rd           (rd),
    .clr_err      (clr_err),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every status output (and dout where defined) against the model.
  task automatic check_status(input string tag);
    int n;
    n = sb.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".af"},    32'(almost_full),  32'(n >= AF));
    check({tag, ".ae"},    32'(almost_empty), 32'(n <= AE));
    check({tag, ".ovf"},   32'(overflow),  32'(m_ov));
    check({tag, ".unf"},   32'(underflow), 32'(m_un));
`ifdef FIFO_FWFT_EN
    if (n > 0) check({tag, ".dout"}, 32'(dout), 32'(sb[0]));
`else
    check({tag, ".dout"}, 32'(dout), 32'(m_dout));
`endif
  endtask

  // One clock of stimulus: update the model from pre-edge state, drive, check.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                      input logic c, input string tag);
    bit rd_ok, wr_ok;
    int n;
    n     = sb.size();
    rd_ok = r && (n > 0);
    wr_ok = w && ((n < DEPTH) || rd_ok);
    if (rd_ok) m_dout = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    m_ov = (m_ov && !c) || (w && !wr_ok);
    m_un = (m_un && !c) || (r && !rd_ok);
    wr = w; din = d; rd = r; clr_err = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    check_status(tag);
  endtask

  initial begin
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = '0;
    m_ov = 1'b0; m_un = 1'b0; m_dout = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_status("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill 0x00..0x0F with no reads.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, WIDTH'(i), 1'b0, 1'b0, "fill");
      if (i == AF - 1) check("af_after_14", 32'(almost_full), 32'd1);
    end
    check("full_after_16", 32'(full), 32'd1);
    check("count_after_16", 32'(count), 32'd16);

    // Write while full is dropped.
    step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf_wr");
    check("ovf_set", 32'(overflow), 32'd1);

    // Drain: scoreboard expects 0x00..0x0F, never 0xAA.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");

    // Underflow, clear, and clear colliding with a new bad read.
    step(1'b0, '0, 1'b1, 1'b0, "unf_rd");
    check("unf_set", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "clr");
    check("unf_cleared", 32'(underflow), 32'd0);
    check("ovf_cleared", 32'(overflow), 32'd0);
    step(1'b0, '0, 1'b1, 1'b1, "clr_vs_unf");
    check("unf_wins_clr", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "clr2");

    // Full, then sustained rd+wr across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0, "fill2");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, WIDTH'(8'h50 + i), 1'b1, 1'b0, "rdwr_full");
      check("rdwr_count", 32'(count), 32'd16);
    end
    check("rdwr_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, "drain2");

    // rd+wr on empty: only the write lands.
    step(1'b1, 8'h5C, 1'b1, 1'b0, "rdwr_empty");
    check("rdwr_empty_unf", 32'(underflow), 32'd1);
    check("rdwr_empty_cnt", 32'(count), 32'd1);
`ifdef FIFO_FWFT_EN
    check("fwft_5c", 32'(dout), 32'h5C);
`endif
    step(1'b0, '0, 1'b1, 1'b0, "rd_5c");
`ifndef FIFO_FWFT_EN
    check("std_5c", 32'(dout), 32'h5C);
`endif

    // Set errors, fill to 7, then async reset between edges.
    step(1'b0, '0, 1'b1, 1'b0, "pre_rst_unf");
    for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(8'hC0 + i), 1'b0, 1'b0, "burst");
    step(1'b0, '0, 1'b1, 1'b0, "burst_rd");
    step(1'b1, 8'hC7, 1'b0, 1'b0, "burst7");
    check("pre_rst_cnt", 32'(count), 32'd7);
    wr = 1'b1; din = 8'hEE;
    #3 rst = 1'b1;
    #1;
    sb.delete();
    m_ov = 1'b0; m_un = 1'b0; m_dout = '0;
    check_status("mid_rst");
    check("mid_rst_dout", 32'(dout), 32'd0);
    #2 rst = 1'b0; wr = 1'b0;
    @(posedge clk);
    #1;
    check_status("post_rst");

    // Normal operation resumes after reset.
    step(1'b1, 8'h3D, 1'b0, 1'b0, "resume_wr");
    step(1'b0, '0, 1'b1, 1'b0, "resume_rd");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
